// File: rtl/rv32i_fetch_pkg.sv
// Shared types and constants for the RV32I fetch slice: the buffered
// {pc, instr} entry and the sequential PC increment.
package rv32i_fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of fetch entries with flush; the head entry is
// read combinationally from storage so decode sees it in the same cycle.
module fetch_fifo
  import rv32i_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t    storage [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  // Pointers wrap naturally because DEPTH is a power of two; the caller
  // never pushes into a full FIFO unless it pops in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) storage[wr_ptr] <= wdata;
  end

  assign rdata = storage[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the fetch PC, reads imem, buffers {pc, instr} for decode.
// Optional FETCH_MISALIGN_TRAP_EN adds a registered fetch_misalign flag.
module instr_fetch_unit
  import rv32i_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        fetch_misalign
`endif
);

  logic [31:0]  fetch_pc;
  logic         push;
  logic         pop;
  logic         full;
  logic         empty;
  fetch_entry_t wentry;
  fetch_entry_t head;

  assign imem_addr = fetch_pc;
  assign if_valid  = !empty && !redirect_valid;
  assign pop       = if_valid && if_ready;
  assign push      = !redirect_valid && (!full || pop);
  assign wentry    = {fetch_pc, imem_rdata};
  assign if_pc     = head.pc;
  assign if_instr  = head.instr;

  // Redirect beats sequential fetch; the target is forced to word alignment.
  always_ff @(posedge clk) begin
    if (!rst_n)
      fetch_pc <= RESET_PC;
    else if (redirect_valid)
      fetch_pc <= redirect_pc & ~32'h3;
    else if (push)
      fetch_pc <= fetch_pc + PC_STEP;
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      fetch_misalign <= 1'b0;
    else
      fetch_misalign <= redirect_valid && (redirect_pc[1:0] != 2'b00);
  end
`endif

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .wdata (wentry),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed table-driven bench for instr_fetch_unit with a preloaded imem model.
module tb_instr_fetch_unit;
  import rv32i_fetch_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misalign;
`endif

  logic [31:0] mem [0:255];
  int          errors = 0;
  int          checks = 0;

  typedef struct {
    logic        rst_n;
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_valid;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] M0 = 32'h00E0_0223;
  localparam logic [31:0] M1 = 32'h0010_0093;
  localparam logic [31:0] M2 = 32'h0020_0113;
  localparam logic [31:0] M3 = 32'h0030_8193;
  localparam logic [31:0] M4 = 32'h0041_0213;
  localparam logic [31:0] M5 = 32'h00C1_2283;
  localparam logic [31:0] MF = 32'hDEAD_BEEF;

  instr_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_misalign (fetch_misalign)
`endif
  );

  assign imem_rdata = mem[imem_addr[9:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic addVec(input logic r, input logic rdy, input logic rv, input logic [31:0] rp,
                        input logic ev, input logic [31:0] ea, input logic [31:0] ep,
                        input logic [31:0] ei, input logic em);
    vec_t v;
    v.rst_n = r; v.ready = rdy; v.redir = rv; v.rpc = rp;
    v.exp_valid = ev; v.exp_addr = ea; v.exp_pc = ep; v.exp_instr = ei; v.exp_mis = em;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic r, input logic rdy, input logic rv, input logic [31:0] rp);
    rst_n          = r;
    if_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rp;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  initial begin
    logic [31:0] exp_next;
    int          pops;

    for (int i = 0; i < 256; i++) mem[i] = INSTR_NOP | (32'(i) << 20);
    mem[0] = M0; mem[1] = M1; mem[2] = M2; mem[3] = M3; mem[4] = M4; mem[5] = M5;
    mem[255] = MF;

    // rst, rdy, redir, rpc, valid, addr, pc, instr, misalign
    addVec(0, 1, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0, 0);
    addVec(1, 1, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0, 0);
    addVec(1, 0, 0, 32'h0,        1, 32'h4,        32'h0,        M0,    0);
    for (int k = 0; k < 4; k++)
      addVec(1, 0, 0, 32'h0,      1, 32'h8,        32'h0,        M0,    0);
    addVec(1, 1, 0, 32'h0,        1, 32'h8,        32'h0,        M0,    0);
    addVec(1, 1, 0, 32'h0,        1, 32'hC,        32'h4,        M1,    0);
    addVec(1, 1, 0, 32'h0,        1, 32'h10,       32'h8,        M2,    0);
    addVec(1, 1, 0, 32'h0,        1, 32'h14,       32'hC,        M3,    0);
    addVec(1, 1, 1, 32'h14,       0, 32'h18,       32'h0,        32'h0, 0);
    addVec(1, 1, 0, 32'h0,        0, 32'h14,       32'h0,        32'h0, 0);
    addVec(1, 1, 0, 32'h0,        1, 32'h18,       32'h14,       M5,    0);
    addVec(1, 0, 1, 32'h16,       0, 32'h1C,       32'h0,        32'h0, 0);
    addVec(1, 0, 0, 32'h0,        0, 32'h14,       32'h0,        32'h0, 1);
    addVec(1, 0, 0, 32'h0,        1, 32'h18,       32'h14,       M5,    0);
    addVec(0, 0, 0, 32'h0,        1, 32'h1C,       32'h14,       M5,    0);
    addVec(0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        32'h0, 0);
    addVec(1, 1, 1, 32'hFFFF_FFFC, 0, 32'h0,       32'h0,        32'h0, 0);
    addVec(1, 1, 0, 32'h0,        0, 32'hFFFF_FFFC, 32'h0,       32'h0, 0);
    addVec(1, 1, 0, 32'h0,        1, 32'h0,        32'hFFFF_FFFC, MF,   0);
    addVec(1, 1, 0, 32'h0,        1, 32'h4,        32'h0,        M0,    0);
    addVec(1, 1, 1, 32'h40,       0, 32'h8,        32'h0,        32'h0, 0);
    addVec(1, 1, 1, 32'h8,        0, 32'h40,       32'h0,        32'h0, 0);
    addVec(1, 1, 0, 32'h0,        0, 32'h8,        32'h0,        32'h0, 0);
    addVec(1, 1, 0, 32'h0,        1, 32'hC,        32'h8,        M2,    0);

    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].ready, vecs[i].redir, vecs[i].rpc);
      @(negedge clk);
      checkOutput($sformatf("v%0d if_valid", i), {31'b0, if_valid}, {31'b0, vecs[i].exp_valid});
      checkOutput($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].exp_addr);
      if (vecs[i].exp_valid) begin
        checkOutput($sformatf("v%0d if_pc", i), if_pc, vecs[i].exp_pc);
        checkOutput($sformatf("v%0d if_instr", i), if_instr, vecs[i].exp_instr);
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      checkOutput($sformatf("v%0d fetch_misalign", i), {31'b0, fetch_misalign}, {31'b0, vecs[i].exp_mis});
`endif
      @(posedge clk);
      #1;
    end

    // Irregular decode back-pressure: every accepted entry must be the next
    // sequential PC with its memory word, nothing lost or repeated.
    exp_next = 32'hC;
    pops = 0;
    for (int k = 0; k < 24; k++) begin
      applyStimulus(1'b1, (k % 3) != 2, 1'b0, 32'h0);
      @(negedge clk);
      if (if_valid && if_ready) begin
        checkOutput($sformatf("order%0d if_pc", k), if_pc, exp_next);
        checkOutput($sformatf("order%0d if_instr", k), if_instr, mem[exp_next[9:2]]);
        exp_next = exp_next + 32'd4;
        pops++;
      end
      @(posedge clk);
      #1;
    end
    checkOutput("order progress", {31'b0, pops >= 10}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
